// File: rtl/queue_calc_pkg.sv
// Shared definitions for the queue calculator: opcodes (common with the ALU),
// sequencer state encoding and error codes.
package queue_calc_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned ERR_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_PUSH = 3'd0,
    OP_POP  = 3'd1,
    OP_ADD  = 3'd2,
    OP_MULL = 3'd3,
    OP_SUB  = 3'd4,
    OP_DIV  = 3'd5,
    OP_REM  = 3'd6,
    OP_ILL  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH,
    ST_POP,
    ST_POP_A,
    ST_POP_B,
    ST_EXEC,
    ST_WRITE,
    ST_ERR
  } state_e;

  typedef enum logic [ERR_W-1:0] {
    ERR_NONE  = 2'd0,
    ERR_UNDER = 2'd1,
    ERR_OVER  = 2'd2,
    ERR_DIVZ  = 2'd3
  } err_e;

endpackage

// File: rtl/queue_calc_ctrl.sv
// Queue calculator sequencer: accepts one instruction at a time, moves operands
// from the operand queue to the ALU and writes results back, flagging faults.
module queue_calc_ctrl
  import queue_calc_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [OP_W-1:0]     instr_op,
  input  logic [DATA_W-1:0]   instr_imm,
  input  logic [CNT_W-1:0]    q_count,
  input  logic [DATA_W-1:0]   q_rdata,
  output logic                q_pop,
  output logic                q_push,
  output logic [DATA_W-1:0]   q_wdata,
  output logic [OP_W-1:0]     alu_opcode,
  output logic [2*DATA_W-1:0] alu_operands,
  output logic [DATA_W-1:0]   alu_push_val,
  input  logic [DATA_W-1:0]   alu_result,
  output logic                pop_valid,
  output logic [DATA_W-1:0]   pop_data,
  output logic                err,
  output logic [ERR_W-1:0]    err_code,
  output logic                busy
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] BIN_MIN  = CNT_W'(2);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, imm_q, imm_d;

  logic                ready_q, ready_d, busy_q, busy_d;
  logic                pop_q, pop_d, push_q, push_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  op_e                 opcode_q, opcode_d;
  logic [2*DATA_W-1:0] operands_q, operands_d;
  logic                pv_q, pv_d;
  logic [DATA_W-1:0]   pdata_q, pdata_d;
  logic                err_q, err_d;
  err_e                ecode_q, ecode_d;

  logic                rej;
  err_e                rej_code;
  logic                div_zero_c;

  assign div_zero_c = ((op_q == OP_DIV) || (op_q == OP_REM)) && (b_q == '0);

  // Next-state, operand capture and next-cycle output values
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    imm_d      = imm_q;
    pop_d      = 1'b0;
    push_d     = 1'b0;
    wdata_d    = '0;
    opcode_d   = OP_POP;
    operands_d = '0;
    pv_d       = 1'b0;
    pdata_d    = '0;
    err_d      = 1'b0;
    ecode_d    = ERR_NONE;
    rej        = 1'b0;
    rej_code   = ERR_NONE;

    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          op_d  = op_e'(instr_op);
          imm_d = instr_imm;
          case (op_e'(instr_op))
            OP_PUSH: begin
              if (q_count >= FULL_CNT) begin
                rej      = 1'b1;
                rej_code = ERR_OVER;
              end else begin
                state_d = ST_PUSH;
                push_d  = 1'b1;
                wdata_d = instr_imm;
              end
            end
            OP_POP: begin
              if (q_count == '0) begin
                rej      = 1'b1;
                rej_code = ERR_UNDER;
              end else begin
                state_d = ST_POP;
                pop_d   = 1'b1;
                pv_d    = 1'b1;
                pdata_d = q_rdata;
              end
            end
            OP_ILL: begin
              rej      = 1'b1;
              rej_code = ERR_DIVZ;
            end
            default: begin
              if (q_count < BIN_MIN) begin
                rej      = 1'b1;
                rej_code = ERR_UNDER;
              end else begin
                state_d = ST_POP_A;
                pop_d   = 1'b1;
              end
            end
          endcase
          if (rej) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            ecode_d = rej_code;
          end
        end
      end
      ST_POP_A: begin
        a_d     = q_rdata;
        pop_d   = 1'b1;
        state_d = ST_POP_B;
      end
      ST_POP_B: begin
        b_d        = q_rdata;
        opcode_d   = op_q;
        operands_d = {a_q, q_rdata};
        state_d    = ST_EXEC;
      end
      ST_EXEC: begin
        push_d  = 1'b1;
        state_d = ST_WRITE;
        if (div_zero_c) begin
          err_d   = 1'b1;
          ecode_d = ERR_DIVZ;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
    busy_d  = !ready_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_PUSH;
      a_q        <= '0;
      b_q        <= '0;
      imm_q      <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      pop_q      <= 1'b0;
      push_q     <= 1'b0;
      wdata_q    <= '0;
      opcode_q   <= OP_POP;
      operands_q <= '0;
      pv_q       <= 1'b0;
      pdata_q    <= '0;
      err_q      <= 1'b0;
      ecode_q    <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      imm_q      <= imm_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      pop_q      <= pop_d;
      push_q     <= push_d;
      wdata_q    <= wdata_d;
      opcode_q   <= opcode_d;
      operands_q <= operands_d;
      pv_q       <= pv_d;
      pdata_q    <= pdata_d;
      err_q      <= err_d;
      ecode_q    <= ecode_d;
    end
  end

  // The ALU result only arrives in WRITE, so write data bypasses the register there
  assign q_wdata      = (state_q == ST_WRITE) ? (div_zero_c ? '0 : alu_result) : wdata_q;
  assign instr_ready  = ready_q;
  assign busy         = busy_q;
  assign q_pop        = pop_q;
  assign q_push       = push_q;
  assign alu_opcode   = opcode_q;
  assign alu_operands = operands_q;
  assign alu_push_val = imm_q;
  assign pop_valid    = pv_q;
  assign pop_data     = pdata_q;
  assign err          = err_q;
  assign err_code     = ecode_q;

endmodule

// File: tb/tb_queue_calc_ctrl.sv
// Bench for queue_calc_ctrl: behavioural operand queue and ALU around the DUT,
// directed scenarios plus random instructions checked against a queue model.
module tb_queue_calc_ctrl;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned CNT_W  = 5;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                instr_valid = 1'b0;
  logic                instr_ready;
  logic [2:0]          instr_op = 3'd0;
  logic [DATA_W-1:0]   instr_imm = '0;
  logic [CNT_W-1:0]    q_count = '0;
  logic [DATA_W-1:0]   q_rdata = '0;
  logic                q_pop, q_push;
  logic [DATA_W-1:0]   q_wdata;
  logic [2:0]          alu_opcode;
  logic [2*DATA_W-1:0] alu_operands;
  logic [DATA_W-1:0]   alu_push_val;
  logic [DATA_W-1:0]   alu_result = '0;
  logic                pop_valid;
  logic [DATA_W-1:0]   pop_data;
  logic                err;
  logic [1:0]          err_code;
  logic                busy;

  queue_calc_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_imm(instr_imm),
    .q_count(q_count), .q_rdata(q_rdata),
    .q_pop(q_pop), .q_push(q_push), .q_wdata(q_wdata),
    .alu_opcode(alu_opcode), .alu_operands(alu_operands),
    .alu_push_val(alu_push_val), .alu_result(alu_result),
    .pop_valid(pop_valid), .pop_data(pop_data),
    .err(err), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Environment: operand queue (show-ahead) and a registered ALU
  logic [DATA_W-1:0] env_q[$];
  logic [DATA_W-1:0] ea, eb;

  always @(posedge clk) begin
    if (q_pop && env_q.size() > 0) void'(env_q.pop_front());
    if (q_push) env_q.push_back(q_wdata);
    q_count <= CNT_W'(env_q.size());
    q_rdata <= (env_q.size() > 0) ? env_q[0] : '0;
  end

  always @(posedge clk) begin
    ea = alu_operands[2*DATA_W-1:DATA_W];
    eb = alu_operands[DATA_W-1:0];
    case (alu_opcode)
      3'd2:    alu_result <= ea + eb;
      3'd3:    alu_result <= DATA_W'(ea * eb);
      3'd4:    alu_result <= ea - eb;
      3'd5:    alu_result <= (eb == 0) ? 8'hFF : ea / eb;
      3'd6:    alu_result <= (eb == 0) ? ea : ea % eb;
      default: alu_result <= '0;
    endcase
  end

  // Event monitor, sampled mid-cycle
  int ncyc = 0, push_cnt = 0, pop_cnt = 0, pv_cnt = 0, err_cnt = 0, ovl_cnt = 0;
  int push_cyc = 0, pop_cyc = 0;
  logic [DATA_W-1:0] push_data = '0, pv_data = '0;
  logic [1:0]        err_code_s = '0;

  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    if (q_push) begin push_cnt <= push_cnt + 1; push_data <= q_wdata; push_cyc <= ncyc; end
    if (q_pop) begin pop_cnt <= pop_cnt + 1; pop_cyc <= ncyc; end
    if (pop_valid) begin pv_cnt <= pv_cnt + 1; pv_data <= pop_data; end
    if (err) begin err_cnt <= err_cnt + 1; err_code_s <= err_code; end
    if ((q_push && q_pop) || (err && pop_valid)) ovl_cnt <= ovl_cnt + 1;
  end

  // Reference model: the queue contents as the architecture defines them
  logic [DATA_W-1:0] ref_q[$];

  task automatic run_instr(input logic [2:0] op, input logic [DATA_W-1:0] imm);
    int exp_err = 0, exp_code = 0, exp_push = 0, exp_pops = 0, exp_pv = 0, exp_lat = 1;
    logic [DATA_W-1:0] exp_wd = '0, exp_pd = '0, a, b;
    int pu0, po0, pv0, er0, ov0, t0, n;
    bit diff;
    case (op)
      3'd0: if (ref_q.size() == DEPTH) begin exp_err = 1; exp_code = 2; end
            else begin exp_push = 1; exp_wd = imm; ref_q.push_back(imm); end
      3'd1: if (ref_q.size() == 0) begin exp_err = 1; exp_code = 1; end
            else begin exp_pops = 1; exp_pv = 1; exp_pd = ref_q.pop_front(); end
      3'd7: begin exp_err = 1; exp_code = 3; end
      default: if (ref_q.size() < 2) begin exp_err = 1; exp_code = 1; end
        else begin
          a = ref_q.pop_front();
          b = ref_q.pop_front();
          exp_pops = 2; exp_push = 1; exp_lat = 4;
          if ((op == 3'd5 || op == 3'd6) && b == 0) begin
            exp_wd = '0; exp_err = 1; exp_code = 3;
          end else begin
            case (op)
              3'd2:    exp_wd = DATA_W'((int'(a) + int'(b)) % 256);
              3'd3:    exp_wd = DATA_W'((int'(a) * int'(b)) % 256);
              3'd4:    exp_wd = DATA_W'((int'(a) - int'(b) + 256) % 256);
              3'd5:    exp_wd = DATA_W'(int'(a) / int'(b));
              default: exp_wd = DATA_W'(int'(a) % int'(b));
            endcase
          end
          ref_q.push_back(exp_wd);
        end
    endcase

    @(negedge clk);
    n = 0;
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    check_eq("ready_idle", 32'(instr_ready), 32'd1);
    pu0 = push_cnt; po0 = pop_cnt; pv0 = pv_cnt; er0 = err_cnt; ov0 = ovl_cnt; t0 = ncyc;
    instr_valid = 1'b1; instr_op = op; instr_imm = imm;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0; instr_imm = $urandom;
    check_eq("ready_low", 32'(instr_ready), 32'd0);
    check_eq("busy_high", 32'(busy), 32'd1);
    n = 0;
    while ((busy || !instr_ready) && n < 20) begin @(negedge clk); n++; end
    check_eq("done_busy", 32'(busy), 32'd0);

    check_eq("err_cnt", 32'(err_cnt - er0), 32'(exp_err));
    if (exp_err != 0) check_eq("err_code", 32'(err_code_s), 32'(exp_code));
    check_eq("push_cnt", 32'(push_cnt - pu0), 32'(exp_push));
    if (exp_push != 0) begin
      check_eq("push_data", 32'(push_data), 32'(exp_wd));
      check_eq("push_lat", 32'(push_cyc - t0), 32'(exp_lat));
    end
    check_eq("pop_cnt", 32'(pop_cnt - po0), 32'(exp_pops));
    if (exp_pops != 0) check_eq("pop_lat", 32'(pop_cyc - t0), 32'(exp_pops));
    check_eq("pv_cnt", 32'(pv_cnt - pv0), 32'(exp_pv));
    if (exp_pv != 0) check_eq("pop_data", 32'(pv_data), 32'(exp_pd));
    check_eq("overlap", 32'(ovl_cnt - ov0), 32'd0);
    check_eq("q_size", 32'(env_q.size()), 32'(ref_q.size()));
    diff = 1'b0;
    if (env_q.size() == ref_q.size())
      for (int i = 0; i < ref_q.size(); i++) if (env_q[i] !== ref_q[i]) diff = 1'b1;
    check_eq("q_data", 32'(diff), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, 32'(instr_ready), 32'd1);
    check_eq({tag, "_ctl"}, {26'd0, busy, q_pop, q_push, pop_valid, err, 1'b0}, 32'd0);
    check_eq({tag, "_opc"}, 32'(alu_opcode), 32'd1);
    check_eq({tag, "_opnd"}, 32'(alu_operands), 32'd0);
    check_eq({tag, "_data"}, {8'd0, q_wdata, pop_data, alu_push_val}, 32'd0);
    check_eq({tag, "_code"}, 32'(err_code), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int pu0;
    int r;
    logic [2:0] op;
    logic [DATA_W-1:0] imm;

    #1 rst = 1'b1;
    #2 check_reset_outputs("rst0");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_instr(3'd0, 8'd5); run_instr(3'd0, 8'd7); run_instr(3'd2, 8'd0);
    check_eq("add_12", 32'(push_data), 32'd12);
    check_eq("add_cnt", 32'(q_count), 32'd1);
    run_instr(3'd1, 8'd0);
    run_instr(3'd0, 8'd3); run_instr(3'd0, 8'd5); run_instr(3'd4, 8'd0);
    check_eq("sub_fe", 32'(push_data), 32'hFE);
    run_instr(3'd1, 8'd0);
    run_instr(3'd0, 8'd200); run_instr(3'd0, 8'd2); run_instr(3'd3, 8'd0);
    check_eq("mull_90", 32'(push_data), 32'h90);
    run_instr(3'd1, 8'd0);
    run_instr(3'd1, 8'd0);
    check_eq("under_code", 32'(err_code_s), 32'd1);
    run_instr(3'd0, 8'd1); run_instr(3'd2, 8'd0); run_instr(3'd1, 8'd0);

    while (ref_q.size() < DEPTH) run_instr(3'd0, 8'($urandom));
    run_instr(3'd0, 8'd9);
    check_eq("over_code", 32'(err_code_s), 32'd2);
    run_instr(3'd1, 8'd0);
    while (ref_q.size() > 0) run_instr(3'd1, 8'd0);

    run_instr(3'd0, 8'd8); run_instr(3'd0, 8'd0); run_instr(3'd5, 8'd0);
    check_eq("div0_data", 32'(push_data), 32'd0);
    check_eq("div0_code", 32'(err_code_s), 32'd3);
    run_instr(3'd7, 8'd0);
    run_instr(3'd1, 8'd0);

    // Reset while an ADD sits in POP_B
    run_instr(3'd0, 8'd11); run_instr(3'd0, 8'd22);
    @(negedge clk);
    pu0 = push_cnt;
    instr_valid = 1'b1; instr_op = 3'd2;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("rst_no_push", 32'(push_cnt - pu0), 32'd0);
    check_eq("rst_ready", 32'(instr_ready), 32'd1);
    void'(ref_q.pop_front());
    check_eq("rst_q_size", 32'(env_q.size()), 32'(ref_q.size()));
    run_instr(3'd1, 8'd0);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 19);
      if (r < 6)       op = 3'd0;
      else if (r < 9)  op = 3'd1;
      else if (r < 19) op = 3'($urandom_range(2, 6));
      else             op = 3'd7;
      imm = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_instr(op, imm);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
